// File: rtl/spi_master_ex.sv
// spi_master_ex: parametrised SPI master (word width, divider, CPOL/CPHA, chip selects); define SPI_RXFIFO_EN for an RX FIFO instead of a hold register
module spi_master_ex #(
    parameter int DATA_W     = 8,
    parameter int NUM_CS     = 2,
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_data,
    input  logic                            rd_data,
    input  logic                            cs_wr,
    input  logic [DATA_W-1:0]               din,
    input  logic [DIV_W-1:0]                div,
    input  logic                            cpol,
    input  logic                            cpha,
    output logic [DATA_W-1:0]               dout,
    output logic                            oe_n,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level,
    output logic                            rx_ovf,
    output logic                            spi_clk,
    output logic                            spi_mosi,
    input  logic                            spi_miso,
    output logic [NUM_CS-1:0]               spi_cs_n
);
    localparam int E_W = $clog2(2 * DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nxt;
    logic [DATA_W-1:0] tx, rx, rx_nxt, rx_word, word;
    logic [DIV_W-1:0] hcnt, div_l;
    logic [E_W-1:0] ecnt;
    logic rd_prev, rd_rise, start, tick, last, lead, sample, shift, cpha_l, sclk, mosi;
    logic [NUM_CS-1:0] cs_n;

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    // next state, SCLK edge timing and strobe decode
    always_comb begin
        rd_rise   = rd_data & ~rd_prev;
        start     = (state == IDLE) & (wr_data | rd_rise);
        word      = wr_data ? din : '1;
        tick      = (state == SHIFT) & (hcnt == div_l);
        last      = tick & (ecnt == E_W'(2 * DATA_W - 1));
        lead      = ~ecnt[0];
        sample    = tick & (lead ^ cpha_l);
        shift     = tick & ~(lead ^ cpha_l) & ~last;
        rx_nxt    = {rx[DATA_W-2:0], spi_miso};
        rx_word   = sample ? rx_nxt : rx;
        state_nxt = start ? SHIFT : last ? IDLE : state;
    end

    // shift engine: divider, edge counter, SCLK level and the two shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_prev <= 1'b0;
            tx      <= '1;
            rx      <= '0;
            hcnt    <= '0;
            ecnt    <= '0;
            div_l   <= '0;
            cpha_l  <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b1;
        end else begin
            rd_prev <= rd_data;
            if (start) begin
                tx     <= cpha ? word : {word[DATA_W-2:0], 1'b1};
                mosi   <= cpha ? 1'b1 : word[DATA_W-1];
                hcnt   <= '0;
                ecnt   <= '0;
                div_l  <= div;
                cpha_l <= cpha;
                sclk   <= cpol;
            end
            if (state == SHIFT) hcnt <= tick ? '0 : hcnt + 1'b1;
            if (tick) begin
                ecnt <= ecnt + 1'b1;
                sclk <= ~sclk;
            end
            if (sample) rx <= rx_nxt;
            if (shift) begin
                tx   <= {tx[DATA_W-2:0], 1'b1};
                mosi <= tx[DATA_W-1];
            end
            if (last) mosi <= 1'b1;
        end
    end

    // chip-select register, writable only between transfers
    always_ff @(posedge clk) cs_n <= rst ? '1 : (cs_wr && state == IDLE) ? ~din[NUM_CS-1:0] : cs_n;

    assign busy     = (state == SHIFT);
    assign spi_clk  = sclk;
    assign spi_mosi = mosi;
    assign spi_cs_n = cs_n;
    assign oe_n     = ~rd_data;

`ifdef SPI_RXFIFO_EN
    localparam int L_W = $clog2(FIFO_DEPTH + 1);
    localparam int A_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [A_W-1:0] wp, rp;
    logic [L_W-1:0] level;
    logic ovf, pop, push;

    // a pop frees a slot in the same cycle, so push-on-full succeeds when paired with a pop
    always_comb begin
        pop  = rd_rise & (level != '0);
        push = last & ((level != L_W'(FIFO_DEPTH)) | pop);
    end

    // FIFO storage
    always_ff @(posedge clk) if (push) mem[wp] <= rx_word;

    // pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= level + L_W'(push) - L_W'(pop);
            if (last & ~push) ovf <= 1'b1;
        end
    end

    assign rx_level = level;
    assign rx_ovf   = ovf;
    assign dout     = rd_data ? ((level == '0) ? '1 : mem[rp]) : '0;
`else
    logic [DATA_W-1:0] hold;

    // hold register takes each completed word
    always_ff @(posedge clk) hold <= rst ? '0 : last ? rx_word : hold;

    assign rx_level = '0;
    assign rx_ovf   = 1'b0;
    assign dout     = rd_data ? hold : '0;
`endif
endmodule
